validador_pecas: RTL and testbench
==================================

VALIDADOR_PECAS -- requirements
Module: validador_pecas

Interface
REQ-001 Parameter TAM_TAB, default 10: board side; legal coordinates are 0..TAM_TAB-1; shall not exceed 16.
REQ-002 One clock; reset is asynchronous and active-high. Ports are named clk and reset.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  async active-high; clears the boards and the FSM.
REQ-005 valida  input  1  check-and-store request; acted on at its 0->1 transition.
REQ-006 tipo  input  3  piece type: 0 submarino (1 cell), 1 cruzador (2), 2 hidroaviao (3, V shape), 3 encouracado (4), 4 porta-avioes (5).
REQ-007 jogador  input  1  target board: 0 or 1.
REQ-008 X1, Y1  input  4 each  anchor cell.
REQ-009 direcao  input  1  0 = horizontal (cells along +X), 1 = vertical (along +Y).
REQ-010 orientacao  input  3  only bit0 is used, and only for hidroaviao (mirror select).
REQ-011 conflito  output  1  result of the last request: 1 = rejected, 0 = stored.
REQ-012 concluido  output  1  one-cycle pulse when a request finishes.
REQ-013 ocupado  output  1  high while a request is in progress.
REQ-014 consulta_jogador  input  1; consulta_x, consulta_y  input  4 each; consulta_celula  output  1  registered occupancy of the addressed cell, valid one cycle after the address; 0 when the address is out of range.

Function
REQ-015 The block holds two TAM_TAB x TAM_TAB occupancy bitmaps, one per jogador.
REQ-016 Cell k of a line piece: horizontal (X1+k, Y1); vertical (X1, Y1+k); k runs from 0 to L-1.
REQ-017 Hidroaviao cells:
- Horizontal, bit0=0: (X1,Y1), (X1+1,Y1+1), (X1+2,Y1).
- Horizontal, bit0=1: (X1,Y1+1), (X1+1,Y1), (X1+2,Y1+1).
- Vertical: the same offsets with the axes swapped.
REQ-018 Cell coordinates are computed 5 bits wide with no wrap-around; a cell is out of bounds when either coordinate is >= TAM_TAB.
REQ-019 States:
- IDLE
- CHECK: one cell per cycle.
- WRITE: one cell per cycle.
- DONE: one cycle.
REQ-020 IDLE to CHECK: in the cycle where valida=1 and its registered previous value was 0, the block latches tipo, jogador, X1, Y1, direcao and orientacao[0], and enters CHECK on the next cycle.
REQ-021 CHECK: the first out-of-bounds or already-occupied cell sends the FSM to DONE with conflict flagged. If all L cells are clear, the FSM goes to WRITE.
REQ-022 WRITE sets the L cells in the latched jogador's bitmap, then goes to DONE with no conflict.
REQ-023 Latency from detected edge to concluido:
- Clean request: 2L+1 cycles.
- Conflict at cell k: k+2 cycles.
REQ-024 In DONE: concluido=1 and conflito is updated. conflito then holds until the next DONE.
REQ-025 tipo greater than 4 goes from CHECK to DONE after one cycle with conflict flagged and no write.
REQ-026 ocupado is high in CHECK, WRITE and DONE.
REQ-027 A valida edge seen while ocupado=1 is ignored and not queued. A level held high never retriggers.
REQ-028 Changing the inputs after the latch cycle has no effect on the request in flight.
REQ-029 The consulta port is independent of the FSM. In the cycle a cell is written, it returns the pre-write value.

Reset
REQ-030 When reset is asserted:
- All bitmap bits clear to 0.
- The FSM returns to IDLE.
- conflito=0, concluido=0, ocupado=0, consulta_celula=0.
- The valida history register clears to 0.
REQ-031 Reset in the middle of WRITE leaves no partial piece, because all bitmaps are cleared.
REQ-032 After reset deasserts, a valida already high is treated as a new 0->1 edge.

Configuration
REQ-033 Macro VALIDADOR_CONTAGEM_EN.
- Defined: the block adds outputs celulas_j0 and celulas_j1 (7 bits each). Each is reset to 0 and increments once per cell written to its board.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Verification
REQ-034 After reset, submarino at jogador 0, (3,4) -> concluido 3 cycles after the edge; conflito=0; consulta(0,3,4)=1; consulta(1,3,4)=0.
REQ-035 Porta-avioes, horizontal, at (6,0) -> cell (10,0) is out of bounds at k=4; concluido 6 cycles after the edge; conflito=1; (6,0) stays 0.
REQ-036 Cruzador, vertical, at (2,2), then encouracado, horizontal, at (0,3) -> the second request conflicts at k=2 (cell (2,3)); conflito=1; concluido after 4 cycles.
REQ-037 Hidroaviao, horizontal, bit0=1, at (0,0) -> cells (0,1), (1,0), (2,1) set and (0,0) clear; with the macro defined, celulas_j0=3.
REQ-038 A second valida edge 2 cycles into a porta-avioes request is ignored, with exactly one concluido pulse. Reset asserted during WRITE leaves all consulta reads at 0.

Source files
------------

// File: rtl/validador_pecas.sv
// Piece placement validator for two square occupancy boards, with a registered cell query port.
// Optional per-board written-cell counters are enabled by defining VALIDADOR_CONTAGEM_EN.
module validador_pecas #(
  parameter int unsigned TAM_TAB = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valida,
  input  logic [2:0] tipo,
  input  logic       jogador,
  input  logic [3:0] X1,
  input  logic [3:0] Y1,
  input  logic       direcao,
  input  logic [2:0] orientacao,
  input  logic       consulta_jogador,
  input  logic [3:0] consulta_x,
  input  logic [3:0] consulta_y,
  output logic       conflito,
  output logic       concluido,
  output logic       ocupado,
  output logic       consulta_celula
`ifdef VALIDADOR_CONTAGEM_EN
  ,
  output logic [6:0] celulas_j0,
  output logic [6:0] celulas_j1
`endif
);

  typedef enum logic [1:0] {StIdle, StCheck, StWrite, StDone} estado_t;

  estado_t estado_q, estado_d;
  logic       valida_q;
  logic [2:0] tipo_q;
  logic       jog_q;
  logic [3:0] x_q, y_q;
  logic       dir_q, esp_q;
  logic [2:0] k_q, k_d;
  logic       conflito_q, conflito_d;
  logic       consulta_q;
  // Boards are stored with a fixed 16-cell row stride; cells beyond TAM_TAB are never written.
  logic [255:0] mapa_q [2];

  logic [2:0] comprimento;
  logic       tipo_ok, inicio, escreve, ultima, fora, ocupada, desvio;
  logic [2:0] dx, dy;
  logic [4:0] cx, cy;
  logic [7:0] celula;
  logic       consulta_ok;
  logic       unused_ori;

  assign unused_ori = ^orientacao[2:1];

  always_comb begin
    comprimento = 3'd0;
    unique case (tipo_q)
      3'd0:    comprimento = 3'd1;
      3'd1:    comprimento = 3'd2;
      3'd2:    comprimento = 3'd3;
      3'd3:    comprimento = 3'd4;
      3'd4:    comprimento = 3'd5;
      default: comprimento = 3'd0;
    endcase
  end

  assign tipo_ok = (tipo_q <= 3'd4);
  assign ultima  = (k_q == comprimento - 3'd1);

  // Hidroaviao zig-zags across the axis: the middle cell steps off-line, mirrored by esp_q.
  assign desvio = (tipo_q == 3'd2) ? ((k_q == 3'd1) ^ esp_q) : 1'b0;
  assign dx     = dir_q ? {2'b00, desvio} : k_q;
  assign dy     = dir_q ? k_q : {2'b00, desvio};
  assign cx     = {1'b0, x_q} + {2'b00, dx};
  assign cy     = {1'b0, y_q} + {2'b00, dy};
  assign fora   = (cx >= 5'(TAM_TAB)) || (cy >= 5'(TAM_TAB));
  assign celula = {cy[3:0], cx[3:0]};
  assign ocupada = !fora && mapa_q[jog_q][celula];

  assign inicio = valida && !valida_q && (estado_q == StIdle);

  always_comb begin
    estado_d   = estado_q;
    k_d        = k_q;
    conflito_d = conflito_q;
    escreve    = 1'b0;
    unique case (estado_q)
      StIdle: begin
        if (inicio) begin
          estado_d = StCheck;
          k_d      = 3'd0;
        end
      end
      StCheck: begin
        if (!tipo_ok || fora || ocupada) begin
          estado_d   = StDone;
          conflito_d = 1'b1;
        end else if (ultima) begin
          estado_d = StWrite;
          k_d      = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      StWrite: begin
        escreve = 1'b1;
        if (ultima) begin
          estado_d   = StDone;
          conflito_d = 1'b0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      StDone:  estado_d = StIdle;
      default: estado_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= StIdle;
      valida_q   <= 1'b0;
      tipo_q     <= 3'd0;
      jog_q      <= 1'b0;
      x_q        <= 4'd0;
      y_q        <= 4'd0;
      dir_q      <= 1'b0;
      esp_q      <= 1'b0;
      k_q        <= 3'd0;
      conflito_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      valida_q   <= valida;
      k_q        <= k_d;
      conflito_q <= conflito_d;
      if (inicio) begin
        tipo_q <= tipo;
        jog_q  <= jogador;
        x_q    <= X1;
        y_q    <= Y1;
        dir_q  <= direcao;
        esp_q  <= orientacao[0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mapa_q[0] <= '0;
      mapa_q[1] <= '0;
    end else if (escreve) begin
      mapa_q[jog_q][celula] <= 1'b1;
    end
  end

  assign consulta_ok = ({1'b0, consulta_x} < 5'(TAM_TAB)) && ({1'b0, consulta_y} < 5'(TAM_TAB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      consulta_q <= 1'b0;
    end else begin
      consulta_q <= consulta_ok && mapa_q[consulta_jogador][{consulta_y, consulta_x}];
    end
  end

`ifdef VALIDADOR_CONTAGEM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      celulas_j0 <= 7'd0;
      celulas_j1 <= 7'd0;
    end else if (escreve) begin
      if (jog_q) celulas_j1 <= celulas_j1 + 7'd1;
      else       celulas_j0 <= celulas_j0 + 7'd1;
    end
  end
`endif

  assign conflito        = conflito_q;
  assign concluido       = (estado_q == StDone);
  assign ocupado         = (estado_q != StIdle);
  assign consulta_celula = consulta_q;

endmodule

// File: tb/tb_validador_pecas.sv
// Directed bench for validador_pecas: a request table, a query table and a few multi-cycle
// sequences (ignored edge, input change in flight, reset during write, valida high over reset).
module tb_validador_pecas;

  logic       clk = 1'b0;
  logic       reset;
  logic       valida;
  logic [2:0] tipo;
  logic       jogador;
  logic [3:0] X1, Y1;
  logic       direcao;
  logic [2:0] orientacao;
  logic       consulta_jogador;
  logic [3:0] consulta_x, consulta_y;
  logic       conflito, concluido, ocupado, consulta_celula;
`ifdef VALIDADOR_CONTAGEM_EN
  logic [6:0] celulas_j0, celulas_j1;
`endif

  validador_pecas #(.TAM_TAB(10)) dut (
    .clk              (clk),
    .reset            (reset),
    .valida           (valida),
    .tipo             (tipo),
    .jogador          (jogador),
    .X1               (X1),
    .Y1               (Y1),
    .direcao          (direcao),
    .orientacao       (orientacao),
    .consulta_jogador (consulta_jogador),
    .consulta_x       (consulta_x),
    .consulta_y       (consulta_y),
    .conflito         (conflito),
    .concluido        (concluido),
    .ocupado          (ocupado),
    .consulta_celula  (consulta_celula)
`ifdef VALIDADOR_CONTAGEM_EN
    ,
    .celulas_j0       (celulas_j0),
    .celulas_j1       (celulas_j1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] tipo;
    logic       jog;
    logic [3:0] x, y;
    logic       dir, ori;
    logic       conf;
    int         lat;
  } req_t;

  typedef struct {
    logic       jog;
    logic [3:0] x, y;
    logic       occ;
  } qry_t;

  req_t reqs[12];
  qry_t qrys[21];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Counts posedges after the edge-latching posedge until concluido is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (concluido) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_req(input req_t r, input string nm);
    int lat;
    @(negedge clk);
    tipo = r.tipo; jogador = r.jog; X1 = r.x; Y1 = r.y;
    direcao = r.dir; orientacao = {2'b00, r.ori};
    valida = 1'b1;
    @(posedge clk);
    wait_done(lat);
    check({nm, " latency"}, lat, r.lat);
    check({nm, " conflito"}, conflito, r.conf);
    valida = 1'b0;
    @(negedge clk);
    check({nm, " pulse"}, concluido, 1'b0);
  endtask

  task automatic query(input logic j, input logic [3:0] x, input logic [3:0] y,
                       input logic exp, input string nm);
    @(negedge clk);
    consulta_jogador = j; consulta_x = x; consulta_y = y;
    @(negedge clk);
    check($sformatf("%s q(%0d,%0d,%0d)", nm, j, x, y), consulta_celula, exp);
  endtask

  initial begin
    int lat, pulses;
    //          tipo  j  x  y  dir ori conf lat
    reqs[0]  = '{3'd0, 0, 3, 4, 0, 0, 0, 3};   // submarino
    reqs[1]  = '{3'd4, 0, 6, 0, 0, 0, 1, 6};   // (10,0) out of bounds at k=4
    reqs[2]  = '{3'd1, 0, 2, 2, 1, 0, 0, 5};
    reqs[3]  = '{3'd3, 0, 0, 3, 0, 0, 1, 4};   // hits (2,3) at k=2
    reqs[4]  = '{3'd2, 0, 0, 0, 0, 1, 0, 7};
    reqs[5]  = '{3'd5, 1, 0, 0, 0, 0, 1, 2};   // invalid tipo
    reqs[6]  = '{3'd0, 1, 9, 9, 0, 0, 0, 3};   // last legal cell
    reqs[7]  = '{3'd0, 1, 9, 9, 0, 0, 1, 2};   // occupied at k=0
    reqs[8]  = '{3'd1, 1, 9, 5, 0, 0, 1, 3};   // out of bounds at k=1
    reqs[9]  = '{3'd2, 1, 0, 0, 1, 0, 0, 7};   // vertical hidro: (0,0),(1,1),(0,2)
    reqs[10] = '{3'd3, 1, 5, 6, 1, 0, 0, 9};
    reqs[11] = '{3'd4, 1, 0, 5, 1, 0, 0, 11};
    qrys[0]  = '{0, 3, 4, 1};  qrys[1]  = '{1, 3, 4, 0};  qrys[2]  = '{0, 6, 0, 0};
    qrys[3]  = '{0, 2, 2, 1};  qrys[4]  = '{0, 2, 3, 1};  qrys[5]  = '{0, 0, 3, 0};
    qrys[6]  = '{0, 1, 3, 0};  qrys[7]  = '{0, 0, 1, 1};  qrys[8]  = '{0, 1, 0, 1};
    qrys[9]  = '{0, 2, 1, 1};  qrys[10] = '{0, 0, 0, 0};  qrys[11] = '{1, 9, 9, 1};
    qrys[12] = '{1, 0, 0, 1};  qrys[13] = '{1, 1, 1, 1};  qrys[14] = '{1, 0, 2, 1};
    qrys[15] = '{1, 1, 0, 0};  qrys[16] = '{1, 5, 9, 1};  qrys[17] = '{1, 0, 9, 1};
    qrys[18] = '{1, 9, 5, 0};  qrys[19] = '{1, 15, 15, 0}; qrys[20] = '{0, 9, 4, 0};

    reset = 1'b1; valida = 1'b0; tipo = '0; jogador = 1'b0; X1 = '0; Y1 = '0;
    direcao = 1'b0; orientacao = '0; consulta_jogador = 1'b0; consulta_x = '0; consulta_y = '0;
    repeat (2) @(negedge clk);
    check("reset conflito", conflito, 0);
    check("reset concluido", concluido, 0);
    check("reset ocupado", ocupado, 0);
    check("reset consulta", consulta_celula, 0);
    reset = 1'b0;

    foreach (reqs[i]) do_req(reqs[i], $sformatf("req%0d", i));
    foreach (qrys[i]) query(qrys[i].jog, qrys[i].x, qrys[i].y, qrys[i].occ, "table");
`ifdef VALIDADOR_CONTAGEM_EN
    check("celulas_j0", celulas_j0, 6);
    check("celulas_j1", celulas_j1, 13);
`endif

    // Second edge while busy is ignored; X1 changed after the latch is ignored too.
    @(negedge clk);
    tipo = 3'd4; jogador = 1'b0; X1 = 4'd0; Y1 = 4'd8; direcao = 1'b0; valida = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy ocupado", ocupado, 1);
    valida = 1'b0; X1 = 4'd9;
    @(negedge clk);
    valida = 1'b1;
    pulses = 0; lat = -1;
    for (int n = 3; n <= 25; n++) begin
      @(negedge clk);
      if (concluido) begin
        pulses++;
        if (lat < 0) lat = n;
      end
    end
    check("busy latency", lat, 11);
    check("busy pulses", pulses, 1);
    check("held no retrigger", ocupado, 0);
    valida = 1'b0;
    query(0, 0, 8, 1, "latched");
    query(0, 4, 8, 1, "latched");
    query(0, 9, 8, 0, "latched");
`ifdef VALIDADOR_CONTAGEM_EN
    check("celulas_j0 busy", celulas_j0, 11);
`endif

    // Reset after two WRITE cycles of a porta-avioes wipes everything.
    @(negedge clk);
    tipo = 3'd4; jogador = 1'b1; X1 = 4'd3; Y1 = 4'd3; direcao = 1'b0; valida = 1'b1;
    @(posedge clk);
    repeat (8) @(negedge clk);
    check("mid write ocupado", ocupado, 1);
    reset = 1'b1;
    #1;
    check("reset ocupado async", ocupado, 0);
    check("reset concluido async", concluido, 0);
    @(negedge clk);
    reset = 1'b0; valida = 1'b0;
    check("reset conflito2", conflito, 0);
    query(1, 3, 3, 0, "wiped");
    query(1, 4, 3, 0, "wiped");
    query(0, 3, 4, 0, "wiped");
    query(1, 9, 9, 0, "wiped");
    repeat (3) @(negedge clk);
    check("no resume after reset", ocupado, 0);
`ifdef VALIDADOR_CONTAGEM_EN
    check("celulas_j1 reset", celulas_j1, 0);
`endif

    // valida already high when reset releases counts as a fresh edge.
    @(negedge clk);
    reset = 1'b1;
    tipo = 3'd0; jogador = 1'b0; X1 = 4'd5; Y1 = 4'd5; direcao = 1'b0; valida = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    wait_done(lat);
    check("post reset latency", lat, 3);
    check("post reset conflito", conflito, 0);
    valida = 1'b0;
    query(0, 5, 5, 1, "post reset");
`ifdef VALIDADOR_CONTAGEM_EN
    check("celulas_j0 post reset", celulas_j0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
